// File: rtl/fpu_mainfsm.sv
// Multicycle processor main control FSM with an FPU execute/writeback path.
// Moore machine: every control output is a function of the current state
// (plus the FPU wait counter for the start pulse). A bounded wait on the FPU
// handshake aborts the instruction without writeback and latches a sticky
// error flag.
module fpu_mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       FPUDone,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       FPUStart,
  output logic       ResSrc,
  output logic       FPUErr,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, FPUEXEC, FPUWB
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       err, err_nx;
  // Low from reset until the first clock edge after release; holds the
  // machine in FETCH for that edge so the first real cycle is a full fetch.
  logic       run;
  logic       quiet;

  logic       irw_raw, npc_raw, regw_raw, memw_raw, br_raw, start_raw;

  // Funct[4:1] carry no control meaning for this FSM.
  logic       unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State, wait counter, sticky error and run flag; reset clears all of them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= 4'd0;
      err   <= 1'b0;
      run   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err   <= err_nx;
      run   <= 1'b1;
    end
  end

  // Next-state, counter and error update; Op/Funct/FPUDone only matter in
  // the states that consult them.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = err;
    if (!run) begin
      state_nx = FETCH;
    end else begin
      case (state)
        FETCH:    state_nx = DECODE;
        DECODE: begin
          case (Op)
            2'b00: state_nx = Funct[5] ? EXECUTEI : EXECUTER;
            2'b01: state_nx = MEMADR;
            2'b10: state_nx = BRANCH;
            2'b11: begin
              state_nx = FPUEXEC;
              cnt_nx   = 4'd0;
            end
            default: state_nx = FETCH;
          endcase
        end
        MEMADR:   state_nx = Funct[0] ? MEMRD : MEMWR;
        MEMRD:    state_nx = MEMWB;
        EXECUTER: state_nx = ALUWB;
        EXECUTEI: state_nx = ALUWB;
        FPUEXEC: begin
          // A result arriving on the last allowed cycle still wins.
          if (FPUDone) begin
            state_nx = FPUWB;
          end else if (cnt == 4'd15) begin
            state_nx = FETCH;
            err_nx   = 1'b1;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        default:  state_nx = FETCH;
      endcase
    end
  end

  // Per-state control decode; write/fetch strobes are gated separately below.
  always_comb begin
    irw_raw   = 1'b0;
    npc_raw   = 1'b0;
    regw_raw  = 1'b0;
    memw_raw  = 1'b0;
    br_raw    = 1'b0;
    start_raw = 1'b0;
    AdrSrc    = 1'b0;
    ALUOp     = 1'b0;
    ResSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        irw_raw   = 1'b1;
        npc_raw   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        regw_raw  = 1'b1;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        memw_raw = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUOp   = 1'b1;
        ALUSrcB = 2'b01;
      end
      ALUWB:    regw_raw = 1'b1;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        br_raw    = 1'b1;
      end
      FPUEXEC: begin
        ResSrc = 1'b1;
        // The counter is zero only on the entry cycle of each visit.
        start_raw = (cnt == 4'd0);
      end
      FPUWB: begin
        ResSrc   = 1'b1;
        regw_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Side-effecting strobes are silenced while in reset and on the
  // post-release alignment cycle.
  assign quiet    = ~reset | ~run;
  assign IRWrite  = irw_raw   & ~quiet;
  assign NextPC   = npc_raw   & ~quiet;
  assign RegW     = regw_raw  & ~quiet;
  assign MemW     = memw_raw  & ~quiet;
  assign Branch   = br_raw    & ~quiet;
  assign FPUStart = start_raw & ~quiet;
  assign FPUErr   = err;

endmodule

// File: doc/fpu_mainfsm.md
FPU_MAINFSM -- requirements
Module: fpu_mainfsm

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit, asynchronous, active-low reset (reset=0 resets).
REQ-003 SHALL have port Op, input, 2 bits, instruction class: 00 data-processing, 01 memory, 10 branch, 11 FPU.
REQ-004 SHALL have port Funct, input, 6 bits; Funct[5] is the immediate select, Funct[0] is load(1)/store(0).
REQ-005 SHALL have port FPUDone, input, 1 bit, FPU result-valid handshake.
REQ-006 SHALL have outputs IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, FPUStart, ResSrc and FPUErr, each 1 bit.
REQ-007 SHALL have outputs ALUSrcA (1 bit), ALUSrcB (2 bits) and ResultSrc (2 bits).

Function
REQ-008 SHALL implement a Moore FSM with 12 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, FPUEXEC, FPUWB.
REQ-009 SHALL use these transitions:
- FETCH->DECODE.
- DECODE, on Op: 00 -> EXECUTER if Funct[5]=0, else EXECUTEI; 01 -> MEMADR; 10 -> BRANCH; 11 -> FPUEXEC.
- MEMADR -> MEMRD if Funct[0]=1, else MEMWR.
- MEMRD -> MEMWB.
- EXECUTER and EXECUTEI -> ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH and FPUWB -> FETCH.
REQ-010 SHALL drive these outputs per state (all unlisted outputs 0):
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1, ALUSrcB=00.
- EXECUTEI: ALUOp=1, ALUSrcB=01.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- FPUEXEC: ResSrc=1.
- FPUWB: ResSrc=1, RegW=1.
REQ-011 SHALL assert FPUStart for exactly the first cycle of each FPUEXEC visit, as a single-cycle pulse.
REQ-012 SHALL keep a 4-bit wait counter that is cleared on entry to FPUEXEC and increments every cycle the FSM stays in FPUEXEC.
REQ-013 SHALL leave FPUEXEC for FPUWB in the cycle after FPUDone=1 is sampled in FPUEXEC; if FPUDone is asserted in the FPUStart cycle, the state is FPUWB on the next cycle.
REQ-014 SHALL, when the counter equals 15 in FPUEXEC and FPUDone=0, go to FETCH and set FPUErr; RegW SHALL NOT be asserted for that instruction.
REQ-015 SHALL give priority to FPUDone when FPUDone=1 and counter=15 occur in the same cycle (go to FPUWB, FPUErr unchanged).
REQ-016 SHALL ignore FPUDone in every state other than FPUEXEC.
REQ-017 SHALL make FPUErr sticky: once set it remains 1 until reset, and further timeouts leave it 1.
REQ-018 SHALL sample Op and Funct only in DECODE and MEMADR; values in other states have no effect.

Reset
REQ-019 SHALL, while reset=0, asynchronously force the state to FETCH, the wait counter to 0 and FPUErr to 0.
REQ-020 SHALL, while reset=0, force IRWrite, NextPC, RegW, MemW, Branch and FPUStart to 0 combinationally; all other outputs take FETCH values.
REQ-021 SHALL, on reset deassertion, make the first rising edge with reset=1 start a FETCH cycle, with FETCH outputs active during that cycle.
REQ-022 SHALL, when reset is asserted mid-instruction (including during FPUEXEC), abandon the instruction; no RegW or MemW pulse follows release.

Verification
REQ-023 SHALL cover: reset release, Op=00, Funct[5]=0 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegW=1 only in cycle 4.
REQ-024 SHALL cover: Op=01, Funct[0]=1 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; AdrSrc=1 in MEMRD; ResultSrc=01 and RegW=1 in MEMWB. Funct[0]=0 -> MEMWR with MemW=1 for exactly 1 cycle.
REQ-025 SHALL cover: Op=11, FPUDone pulsed at wait count 3 -> FPUStart high 1 cycle, ResSrc=1 throughout, FPUWB with RegW=1, then FETCH; FPUErr=0.
REQ-026 SHALL cover: Op=11, FPUDone held 0 -> after 16 FPUEXEC cycles state=FETCH, FPUErr=1, no RegW. A second FPU instruction completing normally leaves FPUErr=1.
REQ-027 SHALL cover: FPUDone=1 together with counter=15 -> FPUWB, FPUErr=0. FPUDone=1 during FETCH and DECODE of an Op=00 instruction -> no effect.
REQ-028 SHALL cover: reset=0 asserted during FPUEXEC at count 7 -> immediate FETCH, counter=0, all write enables 0. After release, a normal fetch with FPUStart=0.
